// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16F84-style execute stage: instruction type codes,
// byte/bit opcode encodings and a bit-mask helper.
package pic_pkg;

  typedef enum logic [1:0] {
    TYPE_BYTE = 2'b00,
    TYPE_BIT  = 2'b01,
    TYPE_CTRL = 2'b10,
    TYPE_LIT  = 2'b11
  } op_type_e;

  localparam logic [3:0] OP_MOVWF  = 4'h0;
  localparam logic [3:0] OP_CLRF   = 4'h1;
  localparam logic [3:0] OP_SUBWF  = 4'h2;
  localparam logic [3:0] OP_DECF   = 4'h3;
  localparam logic [3:0] OP_IORWF  = 4'h4;
  localparam logic [3:0] OP_ANDWF  = 4'h5;
  localparam logic [3:0] OP_XORWF  = 4'h6;
  localparam logic [3:0] OP_ADDWF  = 4'h7;
  localparam logic [3:0] OP_MOVF   = 4'h8;
  localparam logic [3:0] OP_COMF   = 4'h9;
  localparam logic [3:0] OP_INCF   = 4'hA;
  localparam logic [3:0] OP_DECFSZ = 4'hB;
  localparam logic [3:0] OP_RRF    = 4'hC;
  localparam logic [3:0] OP_RLF    = 4'hD;
  localparam logic [3:0] OP_SWAPF  = 4'hE;
  localparam logic [3:0] OP_INCFSZ = 4'hF;

  localparam logic [1:0] BIT_BCF   = 2'b00;
  localparam logic [1:0] BIT_BSF   = 2'b01;
  localparam logic [1:0] BIT_BTFSC = 2'b10;
  localparam logic [1:0] BIT_BTFSS = 2'b11;

  function automatic logic [7:0] bit_mask(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/pic_phase_gen.sv
// Four-phase instruction-cycle ring: {ph_regs, ph_alu, ph_imem, ph_pc}.
// Starts empty in reset and seeds ph_pc on the first edge afterwards.
module pic_phase_gen
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] phase
);

  logic [3:0] phase_q;
  logic [3:0] phase_d;

  always_comb begin
    phase_d = {phase_q[2:0], phase_q[3]};
    if (phase_q == 4'b0000) phase_d = 4'b0001;
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= 4'b0000;
    else       phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/pic_exec_core.sv
// Execute stage: phase strobes, opcode split, and the ALU whose result, flags and
// skip request are captured at the end of the ALU phase.
module pic_exec_core
  import pic_pkg::*;
(
  input  logic       master_clk,
  input  logic       reset,
  input  logic [5:0] full_opcode,
  input  logic [2:0] bit_sel,
  input  logic [7:0] w_in,
  input  logic [7:0] f_in,
  output logic       ph_pc,
  output logic       ph_imem,
  output logic       ph_alu,
  output logic       ph_regs,
  output logic [1:0] type_opcode,
  output logic [3:0] opcode,
  output logic [7:0] alu_out,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_dc,
  output logic       skip,
  output logic       goto_en
);

  logic [3:0] phase;

  pic_phase_gen u_phase (
    .clk   (master_clk),
    .reset (reset),
    .phase (phase)
  );

  assign {ph_regs, ph_alu, ph_imem, ph_pc} = phase;

  op_type_e op_type;
  assign op_type     = op_type_e'(full_opcode[5:4]);
  assign type_opcode = full_opcode[5:4];
  assign opcode      = full_opcode[3:0];
  assign goto_en     = (op_type == TYPE_CTRL);

  logic [7:0] alu_out_q, alu_out_d;
  logic       z_q, z_d, c_q, c_d, dc_q, dc_d, skip_q, skip_d;
  logic       set_z;

  // Carry is bit 8 of a 9-bit sum; for subtraction bit 8 is the borrow, so C is its inverse.
  logic [8:0] add9, sub9, inc9, dec9;
  logic [4:0] add_nib, sub_nib;
  logic [7:0] mask;
  logic       sel_bit;

  assign add9    = {1'b0, f_in} + {1'b0, w_in};
  assign sub9    = {1'b0, f_in} - {1'b0, w_in};
  assign inc9    = {1'b0, f_in} + 9'd1;
  assign dec9    = {1'b0, f_in} - 9'd1;
  assign add_nib = {1'b0, f_in[3:0]} + {1'b0, w_in[3:0]};
  assign sub_nib = {1'b0, f_in[3:0]} - {1'b0, w_in[3:0]};
  assign mask    = bit_mask(bit_sel);
  assign sel_bit = f_in[bit_sel];

  always_comb begin
    alu_out_d = alu_out_q;
    z_d       = z_q;
    c_d       = c_q;
    dc_d      = dc_q;
    skip_d    = 1'b0;
    set_z     = 1'b0;
    unique case (op_type)
      TYPE_BYTE: begin
        unique case (opcode)
          OP_MOVWF:  alu_out_d = w_in;
          OP_CLRF:   begin alu_out_d = 8'h00;        set_z = 1'b1; end
          OP_SUBWF:  begin alu_out_d = sub9[7:0];    set_z = 1'b1;
                           c_d = ~sub9[8]; dc_d = ~sub_nib[4]; end
          OP_DECF:   begin alu_out_d = dec9[7:0];    set_z = 1'b1; end
          OP_IORWF:  begin alu_out_d = f_in | w_in;  set_z = 1'b1; end
          OP_ANDWF:  begin alu_out_d = f_in & w_in;  set_z = 1'b1; end
          OP_XORWF:  begin alu_out_d = f_in ^ w_in;  set_z = 1'b1; end
          OP_ADDWF:  begin alu_out_d = add9[7:0];    set_z = 1'b1;
                           c_d = add9[8]; dc_d = add_nib[4]; end
          OP_MOVF:   begin alu_out_d = f_in;         set_z = 1'b1; end
          OP_COMF:   begin alu_out_d = ~f_in;        set_z = 1'b1; end
          OP_INCF:   begin alu_out_d = inc9[7:0];    set_z = 1'b1; end
          OP_DECFSZ: begin alu_out_d = dec9[7:0];    skip_d = (dec9[7:0] == 8'h00); end
          OP_RRF:    begin alu_out_d = {c_q, f_in[7:1]}; c_d = f_in[0]; end
          OP_RLF:    begin alu_out_d = {f_in[6:0], c_q}; c_d = f_in[7]; end
          OP_SWAPF:  alu_out_d = {f_in[3:0], f_in[7:4]};
          OP_INCFSZ: begin alu_out_d = inc9[7:0];    skip_d = (inc9[7:0] == 8'h00); end
          default:   alu_out_d = alu_out_q;
        endcase
      end
      TYPE_BIT: begin
        unique case (opcode[3:2])
          BIT_BCF:   alu_out_d = f_in & ~mask;
          BIT_BSF:   alu_out_d = f_in | mask;
          BIT_BTFSC: begin alu_out_d = f_in; skip_d = ~sel_bit; end
          BIT_BTFSS: begin alu_out_d = f_in; skip_d = sel_bit; end
          default:   alu_out_d = alu_out_q;
        endcase
      end
      TYPE_CTRL: alu_out_d = w_in;
      TYPE_LIT: begin
        casez (opcode)
          4'b00??: alu_out_d = f_in;
          4'b01??: alu_out_d = f_in;
          4'b1000: begin alu_out_d = f_in | w_in; set_z = 1'b1; end
          4'b1001: begin alu_out_d = f_in & w_in; set_z = 1'b1; end
          4'b1010: begin alu_out_d = f_in ^ w_in; set_z = 1'b1; end
          4'b110?: begin alu_out_d = sub9[7:0];   set_z = 1'b1;
                         c_d = ~sub9[8]; dc_d = ~sub_nib[4]; end
          4'b111?: begin alu_out_d = add9[7:0];   set_z = 1'b1;
                         c_d = add9[8]; dc_d = add_nib[4]; end
          default: alu_out_d = alu_out_q;
        endcase
      end
      default: alu_out_d = alu_out_q;
    endcase
    if (set_z) z_d = (alu_out_d == 8'h00);
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      alu_out_q <= 8'h00;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      dc_q      <= 1'b0;
      skip_q    <= 1'b0;
    end else if (ph_alu) begin
      alu_out_q <= alu_out_d;
      z_q       <= z_d;
      c_q       <= c_d;
      dc_q      <= dc_d;
      skip_q    <= skip_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign flag_dc = dc_q;
  assign skip    = skip_q;

endmodule

// File: tb/tb_pic_exec_core.sv
// Scoreboard bench for pic_exec_core: directed instructions push their hand-computed
// results; a monitor pops and compares them in the write-back phase.
module tb_pic_exec_core;

  logic       master_clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] full_opcode = 6'b0;
  logic [2:0] bit_sel = 3'b0;
  logic [7:0] w_in = 8'h00;
  logic [7:0] f_in = 8'h00;
  logic       ph_pc, ph_imem, ph_alu, ph_regs;
  logic [1:0] type_opcode;
  logic [3:0] opcode;
  logic [7:0] alu_out;
  logic       flag_z, flag_c, flag_dc, skip, goto_en;

  pic_exec_core dut (
    .master_clk  (master_clk),
    .reset       (reset),
    .full_opcode (full_opcode),
    .bit_sel     (bit_sel),
    .w_in        (w_in),
    .f_in        (f_in),
    .ph_pc       (ph_pc),
    .ph_imem     (ph_imem),
    .ph_alu      (ph_alu),
    .ph_regs     (ph_regs),
    .type_opcode (type_opcode),
    .opcode      (opcode),
    .alu_out     (alu_out),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_dc     (flag_dc),
    .skip        (skip),
    .goto_en     (goto_en)
  );

  always #5 master_clk = ~master_clk;

  typedef struct {
    string      name;
    logic [7:0] alu;
    logic       z;
    logic       c;
    logic       dc;
    logic       skp;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  task automatic noteTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for phase strobe", name);
  endtask

  // Monitor: write-back phase is when the captured result is presented.
  initial begin
    forever begin
      @(negedge master_clk);
      if (!reset && ph_regs && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput({e.name, " alu_out"}, alu_out, e.alu);
        checkOutput({e.name, " flag_z"}, {7'b0, flag_z}, {7'b0, e.z});
        checkOutput({e.name, " flag_c"}, {7'b0, flag_c}, {7'b0, e.c});
        checkOutput({e.name, " flag_dc"}, {7'b0, flag_dc}, {7'b0, e.dc});
        checkOutput({e.name, " skip"}, {7'b0, skip}, {7'b0, e.skp});
      end
    end
  end

  task automatic waitPhase(input string name, input int which);
    int guard = 0;
    logic hit;
    do begin
      @(negedge master_clk);
      guard++;
      hit = (which == 1) ? ph_imem : ph_regs;
    end while (!hit && guard < 8);
    if (!hit) noteTimeout(name);
  endtask

  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [2:0] bs,
                               input logic [7:0] w, input logic [7:0] f,
                               input logic [7:0] e_alu, input logic e_z, input logic e_c,
                               input logic e_dc, input logic e_skip);
    exp_t e;
    waitPhase(name, 1);
    full_opcode = op;
    bit_sel     = bs;
    w_in        = w;
    f_in        = f;
    e.name = name; e.alu = e_alu; e.z = e_z; e.c = e_c; e.dc = e_dc; e.skp = e_skip;
    sb_q.push_back(e);
    #1;
    checkOutput({name, " type_opcode"}, {6'b0, type_opcode}, {6'b0, op[5:4]});
    checkOutput({name, " opcode"}, {4'b0, opcode}, {4'b0, op[3:0]});
    checkOutput({name, " goto_en"}, {7'b0, goto_en}, {7'b0, (op[5:4] == 2'b10)});
    waitPhase(name, 4);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_ph [5];
    int guard;
    exp_ph[0] = 4'b0001; exp_ph[1] = 4'b0010; exp_ph[2] = 4'b0100;
    exp_ph[3] = 4'b1000; exp_ph[4] = 4'b0001;

    $display("[TB] reset sequence");
    reset = 1'b1;
    repeat (3) @(negedge master_clk);
    checkOutput("reset phase", {4'b0, ph_regs, ph_alu, ph_imem, ph_pc}, 8'h00);
    checkOutput("reset alu_out", alu_out, 8'h00);
    checkOutput("reset flags", {4'b0, flag_z, flag_c, flag_dc, skip}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge master_clk);
      checkOutput($sformatf("phase step %0d", i), {4'b0, ph_regs, ph_alu, ph_imem, ph_pc},
                  {4'b0, exp_ph[i]});
    end

    $display("[TB] directed instruction vectors");
    //             name       opcode     bs    W      f      alu    Z     C     DC    skip
    applyStimulus("ADDWF",   6'b000111, 3'd0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("SUBWF eq",6'b000010, 3'd0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("SUBWF lt",6'b000010, 3'd0, 8'h05, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("DECFSZ",  6'b001011, 3'd0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("INCFSZ w",6'b001111, 3'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("INCFSZ n",6'b001111, 3'd0, 8'h00, 8'h10, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("BSF",     6'b010100, 3'd3, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("BTFSS",   6'b011100, 3'd7, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("BTFSC",   6'b011000, 3'd7, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ADDWF wr",6'b000111, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("RLF",     6'b001101, 3'd0, 8'h00, 8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("RRF",     6'b001100, 3'd0, 8'h00, 8'h02, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("ADDLW",   6'b111110, 3'd0, 8'h08, 8'h08, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("XORLW",   6'b111010, 3'd0, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("GOTO",    6'b101000, 3'd0, 8'h5A, 8'h33, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("COMF",    6'b001001, 3'd0, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("SUBLW",   6'b111100, 3'd0, 8'h01, 8'h10, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("SWAPF",   6'b001110, 3'd0, 8'h00, 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("BCF",     6'b010000, 3'd0, 8'h00, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset in the middle of a cycle");
    waitPhase("mid reset", 1);
    reset = 1'b1;
    @(negedge master_clk);
    checkOutput("mid reset phase", {4'b0, ph_regs, ph_alu, ph_imem, ph_pc}, 8'h00);
    checkOutput("mid reset alu_out", alu_out, 8'h00);
    checkOutput("mid reset flags", {4'b0, flag_z, flag_c, flag_dc, skip}, 8'h00);
    reset = 1'b0;
    @(negedge master_clk);
    checkOutput("restart phase", {4'b0, ph_regs, ph_alu, ph_imem, ph_pc}, 8'h01);

    $display("[TB] outputs hold outside the ALU phase");
    applyStimulus("MOVLW",   6'b110000, 3'd0, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    full_opcode = 6'b000111;
    w_in        = 8'hFF;
    f_in        = 8'hFF;
    @(negedge master_clk);
    @(negedge master_clk);
    checkOutput("hold phase", {4'b0, ph_regs, ph_alu, ph_imem, ph_pc}, 8'h02);
    checkOutput("hold alu_out", alu_out, 8'h3C);
    checkOutput("hold flags", {4'b0, flag_z, flag_c, flag_dc, skip}, 8'h00);

    guard = 0;
    while (sb_q.size() > 0 && guard < 16) begin
      @(negedge master_clk);
      guard++;
    end
    checkOutput("scoreboard drained", sb_q.size() > 0 ? 8'h01 : 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
